// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
// State encoding, word packing width and default text base.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR =
    32'h0040_0000;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes LSB-first into 32-bit words.
// Pulses o_word_valid the cycle after the 4th byte.
module byte_word_packer
  import mips_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_word;
  logic             r_valid;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_accept && w_last;
      if (i_accept) begin
        r_word[8*r_cnt +: 8] <= i_byte;
        r_cnt                <= r_cnt + 1'b1;
      end
    end
  end

  assign o_last       = w_last;
  assign o_word_valid = r_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/program_loader.sv
// Length-prefixed byte stream to program RAM writer; holds the CPU until loaded.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import mips_loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          LEN_WIDTH    = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_byte_data,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_error
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH + 1);

  state_t               r_state;
  state_t               w_next;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] w_hdr;
  logic [IDX_W-1:0]     r_word_idx;
  logic                 w_accept;
  logic                 w_clear;
  logic                 w_len_bad;
  logic                 w_last_byte;
  logic                 w_pk_last;
  logic                 w_word_valid;
  logic [31:0]          w_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           r_sum;
`endif

  assign w_accept  = i_byte_valid && o_byte_ready;
  assign w_clear   = i_start && (r_state == DONE || r_state == ERR);
  assign w_hdr     = {i_byte_data, r_len[LEN_WIDTH-9:0]};
  assign w_len_bad = (w_hdr == '0) ||
                     (w_hdr > LEN_WIDTH'(MEMORY_DEPTH));

  // Words already written equals word_idx whenever a 4th byte arrives.
  assign w_last_byte = w_pk_last &&
    (LEN_WIDTH'(r_word_idx) == r_len - 1'b1);

  byte_word_packer u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_accept     (w_accept && r_state == DATA),
    .i_byte       (i_byte_data),
    .o_last       (w_pk_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= LEN_LO;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LEN_LO: if (w_accept) w_next = LEN_HI;
      LEN_HI: if (w_accept) w_next = w_len_bad ? ERR : DATA;
      DATA: begin
        if (w_accept && w_last_byte) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = CSUM;
`else
          w_next = DONE;
`endif
        end
      end
      CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_accept)
          w_next = (8'(r_sum + i_byte_data) == 8'h00) ? DONE : ERR;
`else
        w_next = ERR;
`endif
      end
      DONE, ERR: if (i_start) w_next = LEN_LO;
      default: w_next = ERR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_clear) begin
      r_len      <= '0;
      r_word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      if (w_accept && r_state == LEN_LO)
        r_len[7:0] <= i_byte_data;
      if (w_accept && r_state == LEN_HI)
        r_len <= w_hdr;
      if (w_word_valid)
        r_word_idx <= r_word_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (w_accept && r_state != CSUM)
        r_sum <= r_sum + i_byte_data;
`endif
    end
  end

  assign o_byte_ready = !(r_state == DONE || r_state == ERR);
  assign o_mem_we     = w_word_valid;
  assign o_mem_addr   = BASE_ADDR + (32'(r_word_idx) << 2);
  assign o_mem_wdata  = w_word;
  assign o_cpu_hold   = (r_state != DONE);
  assign o_done       = (r_state == DONE);
  assign o_error      = (r_state == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table plus write scoreboard.
// Checksum sequences run when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte_data = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;

  program_loader dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_byte_data  (i_byte_data),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] hdr;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          jitter;
    bit          exp_ok;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        sb[$];
  vec_t       vt[7];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] csum;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  wr_t mon_e;
  always @(negedge i_clk) begin
    if (o_mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 o_mem_addr, o_mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", o_mem_addr, mon_e.addr);
        chk("wr_data", o_mem_wdata, mon_e.data);
      end
    end
  end

  function automatic logic [31:0] word_of(vec_t v, int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return v.w0 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit jit);
    int t;
    if (jit)
      for (int k = 0; k < 3 && $urandom_range(1, 0) == 0; k++) begin
        i_byte_valid = 1'b0;
        @(posedge i_clk); #1;
      end
    i_byte_data  = b;
    i_byte_valid = 1'b1;
    t = 0;
    while (o_byte_ready !== 1'b1 && t < 50) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (t == 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %h ready %b expected 1",
               b, o_byte_ready);
    end else begin
      @(posedge i_clk); #1;
      csum = csum + b;
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic push_wr(input int idx, input logic [31:0] w);
    wr_t e;
    e.addr = BASE + 32'(idx) * 4;
    e.data = w;
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w, input bit jit);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], jit);
  endtask

  task automatic send_image(input vec_t v);
    csum = 8'h00;
    send_byte(v.hdr[7:0], v.jitter);
    send_byte(v.hdr[15:8], v.jitter);
    chk({v.name, "_hdr_err"}, o_error, !v.exp_ok);
    if (v.exp_ok) begin
      for (int i = 0; i < v.nwords; i++) begin
        push_wr(i, word_of(v, i));
        send_word(word_of(v, i), v.jitter);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00 - csum, v.jitter);
`endif
    end
  endtask

  task automatic pulse_start;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic do_reset;
    i_reset      = 1'b1;
    i_byte_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_ready"}, o_byte_ready, 1);
    chk({p, "_hold"}, o_cpu_hold, 1);
    chk({p, "_we"}, o_mem_we, 0);
    chk({p, "_addr"}, o_mem_addr, BASE);
    chk({p, "_wdata"}, o_mem_wdata, 0);
    chk({p, "_done"}, o_done, 0);
    chk({p, "_err"}, o_error, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'h0002, 2, 32'h1234_5678, 32'hDEAD_BEEF, 0, 1, "t1_basic"};
    vt[1] = '{16'h0000, 0, 32'h0, 32'h0, 0, 0, "t2_len0"};
    vt[2] = '{16'h0021, 0, 32'h0, 32'h0, 0, 0, "t3_len33"};
    vt[3] = '{16'h0001, 1, 32'hCAFE_F00D, 32'h0, 0, 1, "len1"};
    vt[4] = '{16'h0020, 32, 32'hA5A5_0001, 32'h0102_0304, 0, 1, "len32"};
    vt[5] = '{16'h0100, 0, 32'h0, 32'h0, 0, 0, "len256"};
    vt[6] = '{16'h0002, 2, 32'h1234_5678, 32'hDEAD_BEEF, 1, 1, "t4_jitter"};

    do_reset;
    chk_reset_vals("rst");

    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        pulse_start;
        chk({vt[i].name, "_start_done"}, o_done, 0);
        chk({vt[i].name, "_start_err"}, o_error, 0);
        chk({vt[i].name, "_start_hold"}, o_cpu_hold, 1);
        chk({vt[i].name, "_start_ready"}, o_byte_ready, 1);
      end
      send_image(vt[i]);
      repeat (3) @(posedge i_clk);
      #1;
      chk({vt[i].name, "_pending"}, sb.size(), 0);
      chk({vt[i].name, "_done"}, o_done, vt[i].exp_ok);
      chk({vt[i].name, "_err"}, o_error, !vt[i].exp_ok);
      chk({vt[i].name, "_hold"}, o_cpu_hold, !vt[i].exp_ok);
      chk({vt[i].name, "_ready"}, o_byte_ready, 0);
    end

    // Reset after 6 data bytes: one write, then outputs at reset values.
    do_reset;
    csum = 8'h00;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    push_wr(0, 32'h1234_5678);
    send_word(32'h1234_5678, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk_reset_vals("t5_midrst");
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("t5_one_write", sb.size(), 0);
    chk("t5_no_write", o_mem_we, 0);
    send_image(vt[0]);
    repeat (3) @(posedge i_clk);
    #1;
    chk("t5_reload_done", o_done, 1);
    chk("t5_reload_pending", sb.size(), 0);

    // start pulse during DATA must be ignored.
    pulse_start;
    csum = 8'h00;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    push_wr(0, 32'h4433_2211);
    send_byte(8'h11, 0);
    pulse_start;
    chk("start_ign_ready", o_byte_ready, 1);
    chk("start_ign_done", o_done, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 - csum, 0);
`endif
    repeat (3) @(posedge i_clk);
    #1;
    chk("start_ign_fin", o_done, 1);
    chk("start_ign_pending", sb.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    pulse_start;
    push_wr(0, 32'h0000_0001);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h0000_0001, 0);
    send_byte(8'hFE, 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("t6_good_done", o_done, 1);
    chk("t6_good_hold", o_cpu_hold, 0);
    pulse_start;
    push_wr(0, 32'h0000_0001);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h0000_0001, 0);
    send_byte(8'hFF, 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("t6_bad_err", o_error, 1);
    chk("t6_bad_hold", o_cpu_hold, 1);
    chk("t6_bad_done", o_done, 0);
    chk("t6_pending", sb.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
